// File: rtl/rv32i_types.sv
// Shared types for the memory-side blocks: the line width and the
// state and grant encodings of the cache arbiter.
package rv32i_types;

  localparam int LINE_WIDTH = 256;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_SERVE_I,
    ARB_SERVE_D
  } arb_state_t;

  typedef enum logic {
    GRANT_I,
    GRANT_D
  } grant_t;

endpackage

// File: rtl/cache_arbiter_if.sv
// Bundle of the I-cache, D-cache and physical memory ports seen by the arbiter.
// The master modport is the arbiter's view; slave is the surrounding system's view.
interface cache_arbiter_if;
  import rv32i_types::*;

  logic                  icache_pmem_read;
  logic [31:0]           icache_pmem_address;
  logic [LINE_WIDTH-1:0] icache_pmem_rdata;
  logic                  icache_pmem_resp;

  logic                  dcache_pmem_read;
  logic                  dcache_pmem_write;
  logic [31:0]           dcache_pmem_address;
  logic [LINE_WIDTH-1:0] dcache_pmem_wdata;
  logic [LINE_WIDTH-1:0] dcache_pmem_rdata;
  logic                  dcache_pmem_resp;

  logic                  mem_read;
  logic                  mem_write;
  logic [31:0]           mem_address;
  logic [LINE_WIDTH-1:0] mem_wdata;
  logic [LINE_WIDTH-1:0] mem_rdata;
  logic                  mem_resp;

  modport master (
    input  icache_pmem_read, icache_pmem_address,
    output icache_pmem_rdata, icache_pmem_resp,
    input  dcache_pmem_read, dcache_pmem_write, dcache_pmem_address, dcache_pmem_wdata,
    output dcache_pmem_rdata, dcache_pmem_resp,
    output mem_read, mem_write, mem_address, mem_wdata,
    input  mem_rdata, mem_resp
  );

  modport slave (
    output icache_pmem_read, icache_pmem_address,
    input  icache_pmem_rdata, icache_pmem_resp,
    output dcache_pmem_read, dcache_pmem_write, dcache_pmem_address, dcache_pmem_wdata,
    input  dcache_pmem_rdata, dcache_pmem_resp,
    input  mem_read, mem_write, mem_address, mem_wdata,
    output mem_rdata, mem_resp
  );

endinterface

// File: rtl/cache_arbiter.sv
// Arbitrates I-cache fills and D-cache fills/writebacks onto one memory port.
// Ties go to the D-cache unless ARB_ROUND_ROBIN_EN is defined, which alternates them.
module cache_arbiter
  import rv32i_types::*;
(
  input logic      clk,
  input logic      rst,
  cache_arbiter_if.master bus
);

  arb_state_t            state;
  arb_state_t            state_next;
  logic [31:0]           addr_q;
  logic [LINE_WIDTH-1:0] wdata_q;
  logic                  write_q;
  logic                  i_req;
  logic                  d_req;
  logic                  grant_now;
  grant_t                grant;
  grant_t                tie_grant;

  assign i_req     = bus.icache_pmem_read;
  assign d_req     = bus.dcache_pmem_read | bus.dcache_pmem_write;
  assign grant_now = (state == ARB_IDLE) && (i_req || d_req);

`ifdef ARB_ROUND_ROBIN_EN
  grant_t last_grant;

  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant <= GRANT_I;
    end else if (grant_now) begin
      last_grant <= grant;
    end
  end

  assign tie_grant = (last_grant == GRANT_I) ? GRANT_D : GRANT_I;
`else
  assign tie_grant = GRANT_D;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ARB_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // The transaction is frozen at grant so requesters may change inputs mid-serve.
  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q  <= '0;
      wdata_q <= '0;
      write_q <= 1'b0;
    end else if (grant_now) begin
      if (grant == GRANT_D) begin
        addr_q  <= bus.dcache_pmem_address;
        write_q <= bus.dcache_pmem_write;
        if (bus.dcache_pmem_write) begin
          wdata_q <= bus.dcache_pmem_wdata;
        end
      end else begin
        addr_q  <= bus.icache_pmem_address;
        write_q <= 1'b0;
      end
    end
  end

  always_comb begin
    state_next           = state;
    grant                = GRANT_I;
    bus.mem_read         = 1'b0;
    bus.mem_write        = 1'b0;
    bus.icache_pmem_resp = 1'b0;
    bus.dcache_pmem_resp = 1'b0;

    if (d_req && (!i_req || tie_grant == GRANT_D)) begin
      grant = GRANT_D;
    end

    case (state)
      ARB_IDLE: begin
        if (i_req || d_req) begin
          state_next = (grant == GRANT_D) ? ARB_SERVE_D : ARB_SERVE_I;
        end
      end
      ARB_SERVE_I: begin
        bus.mem_read         = 1'b1;
        bus.icache_pmem_resp = bus.mem_resp && !rst;
        if (bus.mem_resp) begin
          state_next = ARB_IDLE;
        end
      end
      ARB_SERVE_D: begin
        bus.mem_read         = !write_q;
        bus.mem_write        = write_q;
        bus.dcache_pmem_resp = bus.mem_resp && !rst;
        if (bus.mem_resp) begin
          state_next = ARB_IDLE;
        end
      end
      default: begin
        state_next = ARB_IDLE;
      end
    endcase
  end

  assign bus.mem_address       = addr_q;
  assign bus.mem_wdata         = wdata_q;
  assign bus.icache_pmem_rdata = bus.mem_rdata;
  assign bus.dcache_pmem_rdata = bus.mem_rdata;

endmodule
